// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the packed 8421-BCD to binary converter.
package bcd_pkg;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul10_add.sv
// Combinational Horner step: acc*10 + digit, plus a flag for a non-decimal digit.
module mul10_add #(
  parameter int BIN_W = bcd_pkg::BIN_W
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] sum,
  output logic             invalid
);
  import bcd_pkg::*;

  logic [BIN_W-1:0] times8;
  logic [BIN_W-1:0] times2;

  // Shift-and-add keeps the multiply cheap; wrap-around only happens on invalid input.
  assign times8  = acc << 3;
  assign times2  = acc << 1;
  assign sum     = times8 + times2 + BIN_W'(digit);
  assign invalid = (digit > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd8421_to_bin.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSD first.
module bcd8421_to_bin #(
  parameter int DIGITS = bcd_pkg::DIGITS,
  parameter int BIN_W  = bcd_pkg::BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  err
);
  import bcd_pkg::*;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t              state;
  logic [4*DIGITS-1:0] bcd_q;
  logic [BIN_W-1:0]    acc;
  logic [IDX_W-1:0]    idx;
  logic                err_acc;

  logic [3:0]          digit;
  logic [BIN_W-1:0]    step_sum;
  logic                step_invalid;
  logic                final_err;

  assign digit     = bcd_q[{idx, 2'b00} +: 4];
  assign final_err = err_acc | step_invalid;

  mul10_add #(
    .BIN_W(BIN_W)
  ) u_mul10_add (
    .acc    (acc),
    .digit  (digit),
    .sum    (step_sum),
    .invalid(step_invalid)
  );

  // bin/err only move on DONE entry so they hold the last result through later conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_q   <= '0;
      acc     <= '0;
      idx     <= IDX_LAST;
      err_acc <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_q   <= bcd;
            acc     <= '0;
            err_acc <= 1'b0;
            idx     <= IDX_LAST;
            state   <= CONV;
          end
        end
        CONV: begin
          acc     <= step_sum;
          err_acc <= final_err;
          idx     <= idx - 1'b1;
          if (idx == '0) begin
            bin   <= final_err ? '0 : step_sum;
            err   <= final_err;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CONV);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd8421_to_bin.sv
// Randomised self-checking bench for bcd8421_to_bin against a positional-weight model.
module tb_bcd8421_to_bin;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [13:0] bin;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd8421_to_bin dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bcd  (bcd),
    .busy (busy),
    .done (done),
    .bin  (bin),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each digit weighted by its power of ten; any non-decimal digit zeroes the result.
  function automatic void model(input logic [15:0] v, output logic [13:0] b, output logic e);
    int total;
    int nib;
    total = 0;
    e = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      nib = int'((v >> (4 * d)) & 16'h000F);
      if (nib > 9) e = 1'b1;
      total += nib * (10 ** d);
    end
    b = e ? 14'd0 : total[13:0];
  endfunction

  // Starts one conversion from a negedge and returns what was seen; ends at the negedge after done drops.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cycles,
                          output logic [13:0] b, output logic e, output logic done_after);
    int cnt;
    lat = -1;
    busy_cycles = 0;
    b = '0;
    e = 1'b0;
    done_after = 1'b1;
    start = 1'b1;
    bcd = v;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = cnt - 1;
        b = bin;
        e = err;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    int lat, bc;
    logic [13:0] b;
    logic e, da;
    rst = 1'b1;
    start = 1'b1;
    bcd = 16'h1234;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, bin, err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b bin=%0d err=%0b, want all 0", busy, done, bin, err);
    end
    start = 1'b0;
    rst = 1'b0;
    run_conv(16'h0005, lat, bc, b, e, da);
    n_cmp++;
    if (lat !== 4 || b !== 14'd5 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start_after_reset: got lat=%0d bin=%0d err=%0b, want lat=4 bin=5 err=0", lat, b, e);
    end
  endtask

  task automatic test_valid;
    int lat, bc;
    logic [13:0] b;
    logic e, da;
    run_conv(16'h1234, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'h04D2 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_1234: got bin=%0d err=%0b, want bin=1234 err=0", b, e);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL latency: got %0d, want 4", lat);
    end
    n_cmp++;
    if (bc !== 4) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d, want 4", bc);
    end
    n_cmp++;
    if (da !== 1'b0 || bin !== 14'd1234) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%0b bin=%0d next cycle, want done=0 bin=1234", da, bin);
    end
  endtask

  task automatic test_boundaries;
    int lat, bc;
    logic [13:0] b;
    logic e, da;
    run_conv(16'h9999, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'h270F || e !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL max_9999: got bin=%h err=%0b lat=%0d, want bin=270f err=0 lat=4", b, e, lat);
    end
    run_conv(16'h0000, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'd0 || e !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL zero_0000: got bin=%0d err=%0b lat=%0d, want bin=0 err=0 lat=4", b, e, lat);
    end
  endtask

  task automatic test_invalid;
    int lat, bc;
    logic [13:0] b;
    logic e, da;
    run_conv(16'h12A4, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'd0 || e !== 1'b1 || lat !== 4) begin
      n_fail++;
      $display("FAIL invalid_12A4: got bin=%0d err=%0b lat=%0d, want bin=0 err=1 lat=4", b, e, lat);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_holds: got err=%0b after done, want 1", err);
    end
    run_conv(16'h0042, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'd42 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL after_invalid_0042: got bin=%0d err=%0b, want bin=42 err=0", b, e);
    end
  endtask

  task automatic test_ignored_inputs;
    int lat, bc, dones;
    logic [13:0] b, got;
    logic e, da;
    run_conv(16'h0099, lat, bc, b, e, da);
    start = 1'b1;
    bcd = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || bin !== 14'd99) begin
      n_fail++;
      $display("FAIL hold_during_conv: got busy=%0b bin=%0d, want busy=1 bin=99", busy, bin);
    end
    start = 1'b1;
    bcd = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    got = '0;
    repeat (14) begin
      @(negedge clk);
      if (done) begin
        dones++;
        got = bin;
      end
    end
    n_cmp++;
    if (dones !== 1 || got !== 14'd1234) begin
      n_fail++;
      $display("FAIL ignored_inputs: got %0d done pulses bin=%0d, want 1 pulse bin=1234", dones, got);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones;
    logic [13:0] b;
    logic e, da;
    start = 1'b1;
    bcd = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, bin, err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%0b done=%0b bin=%0d err=%0b, want all 0", busy, done, bin, err);
    end
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL aborted_no_done: got %0d done pulses, want 0", dones);
    end
    run_conv(16'h0007, lat, bc, b, e, da);
    n_cmp++;
    if (b !== 14'd7 || e !== 1'b0 || lat !== 4) begin
      n_fail++;
      $display("FAIL after_reset_0007: got bin=%0d err=%0b lat=%0d, want bin=7 err=0 lat=4", b, e, lat);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, last, seen;
    int gaps[3];
    logic [13:0] vals[3];
    start = 1'b1;
    bcd = 16'h0001;
    cyc = 0;
    last = 0;
    seen = 0;
    while (cyc < 40 && seen < 3) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        vals[seen] = bin;
        gaps[seen] = cyc - last;
        last = cyc;
        seen++;
        bcd = (bcd == 16'h0001) ? 16'h0010 : 16'h0001;
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (seen !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", seen);
    end else begin
      n_cmp++;
      if (vals[0] !== 14'd1 || vals[1] !== 14'd10 || vals[2] !== 14'd1) begin
        n_fail++;
        $display("FAIL b2b_values: got %0d,%0d,%0d want 1,10,1", vals[0], vals[1], vals[2]);
      end
      n_cmp++;
      if (gaps[1] !== 6 || gaps[2] !== 6) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d,%0d cycles, want 6,6", gaps[1], gaps[2]);
      end
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [13:0] b, eb;
    logic e, ee, da;
    logic [15:0] v;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 16'($urandom_range(0, 65535));
      end else begin
        v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      model(v, eb, ee);
      run_conv(v, lat, bc, b, e, da);
      n_cmp++;
      if (b !== eb || e !== ee || lat !== 4) begin
        n_fail++;
        $display("FAIL random_%0d bcd=%h: got bin=%0d err=%0b lat=%0d, want bin=%0d err=%0b lat=4",
                 i, v, b, e, lat, eb, ee);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bcd = 16'h0000;
    @(negedge clk);
    test_reset;
    test_valid;
    test_boundaries;
    test_invalid;
    test_ignored_inputs;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd8421_to_bin.md
BCD8421_TO_BIN -- requirements
Module: bcd8421_to_bin

Interface
REQ-001 Parameter: DIGITS, 4, number of packed 8421-BCD digits; this release supports only 4.
REQ-002 Parameter: BIN_W, 14, binary result width; ceil(log2(10^DIGITS)), so 14 for 4 digits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request a conversion; sampled only in IDLE.
REQ-006 bcd  input  16  packed BCD operand; [15:12] is thousands, [3:0] is units.
REQ-007 busy  output  1  high while in CONV.
REQ-008 done  output  1  one-cycle pulse when a result is published.
REQ-009 bin  output  14  binary result; holds its value between completions.
REQ-010 err  output  1  invalid-digit flag for the last result; holds with bin.

Function
REQ-011 The FSM SHALL have states IDLE, CONV and DONE only.
REQ-012 IDLE with start=1 at edge k: latch bcd, clear acc, clear the error accumulator, set digit index to 3, go to CONV.
REQ-013 CONV SHALL process one digit per edge, most significant first, on edges k+1..k+4: acc <= acc*10 + digit[idx], then idx decrements.
REQ-014 acc*10 SHALL be computed as (acc<<3)+(acc<<1) at BIN_W bits; the maximum 9999 (0x270F) cannot overflow.
REQ-015 Any processed digit > 9 SHALL set the sticky error accumulator; that digit's value is still added, so acc stays defined.
REQ-016 At edge k+4 the FSM SHALL enter DONE and load the outputs: bin = (error ? 0 : final acc), err = error, done = 1.
REQ-017 done SHALL be high for exactly one cycle, between edges k+4 and k+5, then the FSM returns to IDLE.
REQ-018 Latency from the start-sampling edge to done high SHALL be 4 cycles; throughput is one conversion per 6 cycles.
REQ-019 busy SHALL be 1 from edge k to edge k+4, and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in CONV and DONE; it is not queued.
REQ-021 bcd SHALL be ignored except at the IDLE start edge; changing it mid-conversion has no effect.
REQ-022 bin and err SHALL NOT change except at DONE entry or reset; they are not cleared when a new start is accepted.
REQ-023 If start is held high continuously, a new conversion SHALL begin at every IDLE edge, one every 6 cycles.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and set busy=0, done=0, bin=0, err=0, acc=0, idx=3 and the error accumulator to 0.
REQ-025 Reset SHALL take priority over start and over any in-progress CONV; an aborted conversion produces no done.
REQ-026 The first start is honoured at the first edge with rst=0.

Structure
REQ-027 Shared package bcd_pkg SHALL hold DIGITS, BIN_W, the BCD_MAX_DIGIT=9 constant and the state enum (IDLE, CONV, DONE).
REQ-028 One combinational sub-module, mul10_add, SHALL compute (acc*10 + digit) and flag digit > 9; the FSM, registers and output logic stay in the top.

Verification
REQ-029 Valid operand: bcd=0x1234 with a start pulse -> done 4 cycles later, bin=1234 (0x04D2), err=0, busy high exactly 4 cycles.
REQ-030 Boundaries: bcd=0x9999 -> bin=0x270F, err=0; bcd=0x0000 -> bin=0, err=0.
REQ-031 Invalid digit: bcd=0x12A4 -> bin=0, err=1; a following bcd=0x0042 -> bin=42, err=0.
REQ-032 Ignored inputs: start pulsed and bcd changed to 0x5555 during CONV -> a single done with the original result (0x1234 -> 1234).
REQ-033 Reset mid-operation: rst at CONV cycle 2 -> no done, all outputs 0; the next start with 0x0007 -> bin=7 after 4 cycles.
REQ-034 Back-to-back: start held high with alternating 0x0001 and 0x0010 -> done pulses 6 cycles apart, results 1 then 10.
